// File: rtl/img_mem_pkg.sv
// -----------------------------------------------------------------------------
// img_mem_pkg
// Shared definitions for the image-memory responder (img_mem_server):
//   - state_t           : LOAD / SERVE / DRAIN controller states
//   - calc_w_addr()     : linear pixel address width for a width x height frame
//   - calc_frame_pixels : pixel count for a width x height frame
//   - FRAME_PIXELS      : pixel count of the default 41x50 frame
// -----------------------------------------------------------------------------
package img_mem_pkg;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,  // accepting the raster-order load stream
    ST_SERVE = 2'd1,  // answering address requests
    ST_DRAIN = 2'd2   // reload requested, waiting for in-flight pixels to leave
  } state_t;

  localparam int DEF_IMG_WIDTH  = 41;
  localparam int DEF_IMG_HEIGHT = 50;
  localparam int FRAME_PIXELS   = DEF_IMG_WIDTH * DEF_IMG_HEIGHT;

  function automatic int calc_frame_pixels(input int width, input int height);
    return width * height;
  endfunction

  function automatic int calc_w_addr(input int width, input int height);
    return $clog2(width * height);
  endfunction

endpackage

// File: rtl/img_mem_server_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock show-ahead FIFO used as the return-data buffer.
// Ports:
//   clk, rst        : rising-edge clock, synchronous active-high reset
//   push, push_data : write one entry (caller guarantees not full)
//   pop             : drop the head entry (caller guarantees not empty)
//   head            : current head entry, 0 while empty
//   count           : number of stored entries (0..DEPTH)
// -----------------------------------------------------------------------------
module sync_fifo #(
  parameter  int DEPTH  = 4,
  parameter  int W_DATA = 8,
  localparam int W_CNT  = $clog2(DEPTH + 1),
  localparam int W_PTR  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [W_DATA-1:0] push_data,
  input  logic              pop,
  output logic [W_DATA-1:0] head,
  output logic [W_CNT-1:0]  count
);

  localparam logic [W_PTR-1:0] LAST_PTR = W_PTR'(DEPTH - 1);

  logic [W_DATA-1:0] mem [DEPTH];
  logic [W_PTR-1:0]  wr_ptr;
  logic [W_PTR-1:0]  rd_ptr;

  // NOTE: storage arrays are never reset; only pointers and counts are, so
  // the array maps onto plain RAM/registers without reset muxes.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // NOTE: sequential state is always updated with <= so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
    end
  end

  assign head = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/img_mem_server.sv
// -----------------------------------------------------------------------------
// img_mem_server
// Holds one IMG_WIDTH x IMG_HEIGHT grayscale frame in on-chip RAM, loaded as a
// raster-order stream, and serves linear-address read requests with pixels
// returned in request order. A credit counter (pend) bounds outstanding
// requests to DEPTH so the return FIFO can never overflow under backpressure.
// Ports:
//   clk, rst                  : rising-edge clock, synchronous active-high reset
//   wr_valid/wr_ready/wr_data : frame load stream (accepted in LOAD only)
//   reload                    : pulse in SERVE to start a new frame load
//   loaded                    : high while serving
//   addr_valid/addr_ready/addr: read requests, address = y*IMG_WIDTH+x
//   dout_valid/dout_ready/dout_data : returned pixel stream
//   err                       : sticky out-of-range flag
// Build option: define IMG_MEM_OOB_CHECK_EN to return 0 for out-of-range
// addresses and raise err; otherwise no range check and err is tied 0.
// -----------------------------------------------------------------------------
module img_mem_server
  import img_mem_pkg::*;
#(
  parameter  int W_DATA     = 8,
  parameter  int IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter  int IMG_HEIGHT = DEF_IMG_HEIGHT,
  parameter  int DEPTH      = 4,
  localparam int W_ADDR     = calc_w_addr(IMG_WIDTH, IMG_HEIGHT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [W_DATA-1:0] wr_data,
  input  logic              reload,
  output logic              loaded,
  input  logic              addr_valid,
  output logic              addr_ready,
  input  logic [W_ADDR-1:0] addr,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic [W_DATA-1:0] dout_data,
  output logic              err
);

  localparam int                N_PIX    = calc_frame_pixels(IMG_WIDTH, IMG_HEIGHT);
  localparam int                W_PEND   = $clog2(DEPTH + 1);
  localparam logic [W_ADDR-1:0] LAST_PIX = W_ADDR'(N_PIX - 1);
  localparam logic [W_PEND-1:0] PEND_MAX = W_PEND'(DEPTH);

  state_t            state;
  logic [W_ADDR-1:0] wr_cnt;
  logic [W_PEND-1:0] pend;       // accepted requests not yet popped from dout
  logic [W_DATA-1:0] mem [N_PIX];
  logic [W_DATA-1:0] rd_data;
  logic              rd_valid;   // rd_data is pushed into the FIFO this cycle
  logic [W_DATA-1:0] push_data;
  logic [W_PEND-1:0] fifo_count;
  logic              wr_fire;
  logic              addr_fire;
  logic              dout_fire;

  // Ready signals depend on registered state only, never on the partner's valid.
  assign wr_ready   = (state == ST_LOAD);
  assign loaded     = (state == ST_SERVE);
  assign addr_ready = (state == ST_SERVE) && (pend < PEND_MAX);
  assign dout_valid = (fifo_count != '0);

  assign wr_fire   = wr_valid && wr_ready;
  assign addr_fire = addr_valid && addr_ready;
  assign dout_fire = dout_valid && dout_ready;

  // Frame RAM: one write port (load stream), one registered read port.
  always_ff @(posedge clk) begin
    if (wr_fire)   mem[wr_cnt] <= wr_data;
    if (addr_fire) rd_data     <= mem[addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_LOAD;
      wr_cnt   <= '0;
      pend     <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= addr_fire;

      if (addr_fire && !dout_fire)      pend <= pend + 1'b1;
      else if (!addr_fire && dout_fire) pend <= pend - 1'b1;

      unique case (state)
        ST_LOAD: begin
          if (wr_fire) begin
            if (wr_cnt == LAST_PIX) begin
              wr_cnt <= '0;
              state  <= ST_SERVE;
            end else begin
              wr_cnt <= wr_cnt + 1'b1;
            end
          end
        end
        ST_SERVE: if (reload) state <= ST_DRAIN;
        // pend covers the RAM stage and the FIFO, so zero means fully empty.
        ST_DRAIN: if (pend == '0) state <= ST_LOAD;
        default:  state <= ST_LOAD;
      endcase
    end
  end

`ifdef IMG_MEM_OOB_CHECK_EN
  logic addr_oob;
  logic rd_oob;
  logic err_q;

  // Extra MSB so the compare stays correct when N_PIX is a power of two.
  assign addr_oob = ({1'b0, addr} >= (W_ADDR + 1)'(N_PIX));

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_oob <= 1'b0;
      err_q  <= 1'b0;
    end else if (addr_fire) begin
      rd_oob <= addr_oob;
      if (addr_oob) err_q <= 1'b1;
    end
  end

  // Masking after the RAM register keeps the read path a plain block RAM.
  assign push_data = rd_oob ? '0 : rd_data;
  assign err       = err_q;
`else
  assign push_data = rd_data;
  assign err       = 1'b0;
`endif

  sync_fifo #(
    .DEPTH  (DEPTH),
    .W_DATA (W_DATA)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rd_valid),
    .push_data (push_data),
    .pop       (dout_fire),
    .head      (dout_data),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_img_mem_server.sv
// -----------------------------------------------------------------------------
// tb_img_mem_server
// Directed bench for img_mem_server: inputs change on the falling edge,
// outputs are observed on the falling edge, handshakes resolve on the rising
// edge. A frame model array supplies every expected pixel.
// -----------------------------------------------------------------------------
module tb_img_mem_server;

  localparam int W_DATA     = 8;
  localparam int IMG_WIDTH  = 41;
  localparam int IMG_HEIGHT = 50;
  localparam int DEPTH      = 4;
  localparam int N_PIX      = IMG_WIDTH * IMG_HEIGHT;
  localparam int W_ADDR     = 12;

  logic              clk;
  logic              rst;
  logic              wr_valid;
  logic              wr_ready;
  logic [W_DATA-1:0] wr_data;
  logic              reload;
  logic              loaded;
  logic              addr_valid;
  logic              addr_ready;
  logic [W_ADDR-1:0] addr;
  logic              dout_valid;
  logic              dout_ready;
  logic [W_DATA-1:0] dout_data;
  logic              err;

  int vectors    = 0;
  int miscompares = 0;

  logic [W_DATA-1:0] model [N_PIX];

  img_mem_server #(
    .W_DATA     (W_DATA),
    .IMG_WIDTH  (IMG_WIDTH),
    .IMG_HEIGHT (IMG_HEIGHT),
    .DEPTH      (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_data    (wr_data),
    .reload     (reload),
    .loaded     (loaded),
    .addr_valid (addr_valid),
    .addr_ready (addr_ready),
    .addr       (addr),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_data  (dout_data),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    wr_valid   = 1'b0;
    wr_data    = '0;
    reload     = 1'b0;
    addr_valid = 1'b0;
    addr       = '0;
    dout_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (3) @(negedge clk);
    vectors++; if (wr_ready !== 1'b1)   begin miscompares++; $display("FAIL reset_wr_ready: got %b want 1", wr_ready); end
    vectors++; if (loaded !== 1'b0)     begin miscompares++; $display("FAIL reset_loaded: got %b want 0", loaded); end
    vectors++; if (addr_ready !== 1'b0) begin miscompares++; $display("FAIL reset_addr_ready: got %b want 0", addr_ready); end
    vectors++; if (dout_valid !== 1'b0) begin miscompares++; $display("FAIL reset_dout_valid: got %b want 0", dout_valid); end
    vectors++; if (dout_data !== 8'h00) begin miscompares++; $display("FAIL reset_dout_data: got %0h want 0", dout_data); end
    vectors++; if (err !== 1'b0)        begin miscompares++; $display("FAIL reset_err: got %b want 0", err); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Loads pixel i = (i*mul + add) mod 256 and updates the model.
  task automatic load_frame(input int mul, input int add);
    int stray = 0;
    vectors++; if (wr_ready !== 1'b1) begin miscompares++; $display("FAIL load_start_wr_ready: got %b want 1", wr_ready); end
    for (int i = 0; i < N_PIX; i++) begin
      model[i] = 8'((i * mul + add) % 256);
      wr_valid = 1'b1;
      wr_data  = model[i];
      if (dout_valid) stray++;
      if (i == N_PIX - 1) begin
        vectors++; if (loaded !== 1'b0) begin miscompares++; $display("FAIL load_last_loaded_early: got %b want 0", loaded); end
      end
      @(negedge clk);
    end
    wr_valid = 1'b0;
    vectors++; if (loaded !== 1'b1)     begin miscompares++; $display("FAIL load_done_loaded: got %b want 1", loaded); end
    vectors++; if (addr_ready !== 1'b1) begin miscompares++; $display("FAIL load_done_addr_ready: got %b want 1", addr_ready); end
    vectors++; if (wr_ready !== 1'b0)   begin miscompares++; $display("FAIL load_done_wr_ready: got %b want 0", wr_ready); end
    vectors++; if (stray != 0)          begin miscompares++; $display("FAIL load_stray_dout: got %0d cycles want 0", stray); end
  endtask

  task automatic test_basic_read();
    dout_ready = 1'b1;
    addr_valid = 1'b1;
    addr       = 12'd0;
    @(negedge clk);
    vectors++; if (dout_valid !== 1'b0) begin miscompares++; $display("FAIL basic_latency_n1: got %b want 0", dout_valid); end
    addr = 12'd1;
    @(negedge clk);
    vectors++; if (dout_valid !== 1'b1 || dout_data !== 8'd0) begin miscompares++; $display("FAIL basic_addr0: got v=%b d=%0d want v=1 d=0", dout_valid, dout_data); end
    addr = 12'd2049;
    @(negedge clk);
    vectors++; if (dout_valid !== 1'b1 || dout_data !== 8'd1) begin miscompares++; $display("FAIL basic_addr1: got v=%b d=%0d want v=1 d=1", dout_valid, dout_data); end
    addr_valid = 1'b0;
    @(negedge clk);
    vectors++; if (dout_valid !== 1'b1 || dout_data !== 8'd1) begin miscompares++; $display("FAIL basic_addr2049: got v=%b d=%0d want v=1 d=1", dout_valid, dout_data); end
    @(negedge clk);
    vectors++; if (dout_valid !== 1'b0) begin miscompares++; $display("FAIL basic_empty_after: got %b want 0", dout_valid); end
    dout_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int acc = 0;
    dout_ready = 1'b0;
    addr_valid = 1'b1;
    for (int c = 0; c < 8; c++) begin
      addr = W_ADDR'(10 + acc);
      if (addr_ready) acc++;
      @(negedge clk);
    end
    addr_valid = 1'b0;
    vectors++; if (acc != DEPTH)        begin miscompares++; $display("FAIL bp_accepts: got %0d want %0d", acc, DEPTH); end
    vectors++; if (addr_ready !== 1'b0) begin miscompares++; $display("FAIL bp_addr_ready_full: got %b want 0", addr_ready); end
    vectors++; if (dout_valid !== 1'b1 || dout_data !== model[10]) begin miscompares++; $display("FAIL bp_stalled_head: got v=%b d=%0d want v=1 d=%0d", dout_valid, dout_data, model[10]); end
    dout_ready = 1'b1;
    @(negedge clk);
    vectors++; if (addr_ready !== 1'b1) begin miscompares++; $display("FAIL bp_credit_return: got %b want 1", addr_ready); end
    for (int k = 11; k <= 13; k++) begin
      vectors++; if (dout_valid !== 1'b1 || dout_data !== model[k]) begin miscompares++; $display("FAIL bp_drain_%0d: got v=%b d=%0d want v=1 d=%0d", k, dout_valid, dout_data, model[k]); end
      @(negedge clk);
    end
    vectors++; if (dout_valid !== 1'b0) begin miscompares++; $display("FAIL bp_empty_after: got %b want 0", dout_valid); end
    dout_ready = 1'b0;
  endtask

  task automatic test_reload_drain();
    logic [W_DATA-1:0] exp_q [3];
    int got = 0;
    int budget = 0;
    int early = 0;
    exp_q[0] = model[100];
    exp_q[1] = model[200];
    exp_q[2] = model[300];
    dout_ready = 1'b0;
    addr_valid = 1'b1;
    addr = 12'd100;
    @(negedge clk);
    addr = 12'd200;
    @(negedge clk);
    addr   = 12'd300;
    reload = 1'b1;  // same cycle as an accept: the request must still be served
    @(negedge clk);
    addr_valid = 1'b0;
    reload     = 1'b0;
    vectors++; if (loaded !== 1'b0)     begin miscompares++; $display("FAIL reload_loaded: got %b want 0", loaded); end
    vectors++; if (addr_ready !== 1'b0) begin miscompares++; $display("FAIL reload_addr_ready: got %b want 0", addr_ready); end
    repeat (2) @(negedge clk);
    vectors++; if (wr_ready !== 1'b0) begin miscompares++; $display("FAIL reload_wr_ready_pending: got %b want 0", wr_ready); end
    dout_ready = 1'b1;
    while (got < 3 && budget < 20) begin
      if (wr_ready) early++;
      if (dout_valid) begin
        vectors++; if (dout_data !== exp_q[got]) begin miscompares++; $display("FAIL reload_data_%0d: got %0d want %0d", got, dout_data, exp_q[got]); end
        got++;
      end
      @(negedge clk);
      budget++;
    end
    vectors++; if (got != 3)   begin miscompares++; $display("FAIL reload_delivered: got %0d want 3", got); end
    vectors++; if (early != 0) begin miscompares++; $display("FAIL reload_wr_ready_early: got %0d cycles want 0", early); end
    budget = 0;
    while (!wr_ready && budget < 10) begin
      @(negedge clk);
      budget++;
    end
    vectors++; if (wr_ready !== 1'b1) begin miscompares++; $display("FAIL reload_enter_load: got %b want 1", wr_ready); end
    dout_ready = 1'b0;
  endtask

  task automatic test_rst_mid_serve();
    dout_ready = 1'b0;
    addr_valid = 1'b1;
    addr = 12'd5;
    @(negedge clk);
    addr = 12'd6;
    @(negedge clk);
    addr_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vectors++; if (dout_valid !== 1'b0) begin miscompares++; $display("FAIL rst_mid_dout_valid: got %b want 0", dout_valid); end
    vectors++; if (wr_ready !== 1'b1)   begin miscompares++; $display("FAIL rst_mid_wr_ready: got %b want 1", wr_ready); end
    vectors++; if (loaded !== 1'b0)     begin miscompares++; $display("FAIL rst_mid_loaded: got %b want 0", loaded); end
    load_frame(5, 13);
    dout_ready = 1'b1;
    addr_valid = 1'b1;
    addr = 12'd5;
    @(negedge clk);
    addr = 12'd6;
    @(negedge clk);
    addr_valid = 1'b0;
    vectors++; if (dout_valid !== 1'b1 || dout_data !== model[5]) begin miscompares++; $display("FAIL rst_new_frame_5: got v=%b d=%0d want v=1 d=%0d", dout_valid, dout_data, model[5]); end
    @(negedge clk);
    vectors++; if (dout_valid !== 1'b1 || dout_data !== model[6]) begin miscompares++; $display("FAIL rst_new_frame_6: got v=%b d=%0d want v=1 d=%0d", dout_valid, dout_data, model[6]); end
    @(negedge clk);
    dout_ready = 1'b0;
  endtask

  task automatic test_oob();
    dout_ready = 1'b1;
    addr_valid = 1'b1;
    addr = 12'd2050;
    @(negedge clk);
`ifdef IMG_MEM_OOB_CHECK_EN
    vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL oob_err_next_cycle: got %b want 1", err); end
`endif
    addr = 12'd7;
    @(negedge clk);
    addr_valid = 1'b0;
    vectors++; if (dout_valid !== 1'b1) begin miscompares++; $display("FAIL oob_dout_valid: got %b want 1", dout_valid); end
`ifdef IMG_MEM_OOB_CHECK_EN
    vectors++; if (dout_data !== 8'h00) begin miscompares++; $display("FAIL oob_data_zero: got %0h want 0", dout_data); end
`endif
    @(negedge clk);
    vectors++; if (dout_valid !== 1'b1 || dout_data !== model[7]) begin miscompares++; $display("FAIL oob_in_order: got v=%b d=%0d want v=1 d=%0d", dout_valid, dout_data, model[7]); end
    repeat (3) @(negedge clk);
`ifdef IMG_MEM_OOB_CHECK_EN
    vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL oob_err_sticky: got %b want 1", err); end
`else
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL oob_err_tied: got %b want 0", err); end
`endif
    dout_ready = 1'b0;
  endtask

  task automatic test_random_traffic();
    logic [W_DATA-1:0] sbq [$];
    logic [W_DATA-1:0] exp_d;
    int acc = 0;
    int cyc = 0;
    while ((acc < 10000 || sbq.size() > 0) && cyc < 80000) begin
      addr_valid = (acc < 10000) ? 1'($urandom_range(0, 1)) : 1'b0;
      addr       = W_ADDR'($urandom_range(0, N_PIX - 1));
      dout_ready = 1'($urandom_range(0, 1));
      if (addr_valid && addr_ready) begin
        sbq.push_back(model[addr]);
        acc++;
      end
      if (dout_valid && dout_ready) begin
        vectors++;
        if (sbq.size() == 0) begin
          miscompares++; $display("FAIL rand_unexpected: got d=%0d with empty scoreboard want no output", dout_data);
        end else begin
          exp_d = sbq.pop_front();
          if (dout_data !== exp_d) begin miscompares++; $display("FAIL rand_data: got %0d want %0d", dout_data, exp_d); end
        end
      end
      @(negedge clk);
      cyc++;
    end
    addr_valid = 1'b0;
    dout_ready = 1'b0;
    vectors++; if (acc != 10000)     begin miscompares++; $display("FAIL rand_accepts: got %0d want 10000", acc); end
    vectors++; if (sbq.size() != 0)  begin miscompares++; $display("FAIL rand_outstanding: got %0d want 0", sbq.size()); end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    load_frame(1, 0);
    test_basic_read();
    test_backpressure();
    test_reload_drain();
    load_frame(3, 77);
    test_rst_mid_serve();
    test_oob();
    test_random_traffic();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/img_mem_server.md
# img_mem_server

Responder side of the image-memory fetch protocol. Holds one IMG_WIDTH×IMG_HEIGHT grayscale frame in on-chip RAM, loaded as a raster-order pixel stream. It serves address requests from the classifier's data fetcher (addr valid/ready) with pixel data returned in request order on a valid/ready stream. It sits between the frame source and the fetcher/eot generator path, and provides credit-based flow control so no returned pixel is ever dropped under backpressure.

## Interface
Parameters:
- W_DATA, 8, pixel width
- IMG_WIDTH, 41, frame width in pixels
- IMG_HEIGHT, 50, frame height in pixels
- DEPTH, 4, output FIFO depth and maximum outstanding requests; must be ≥ 3 for full throughput
- W_ADDR (localparam), $clog2(IMG_WIDTH*IMG_HEIGHT)

Ports:
- clk  in  1  single clock; all logic rising-edge
- rst  in  1  synchronous, active-high reset
- wr_valid  in  1  load-stream pixel valid
- wr_ready  out  1  high in LOAD state
- wr_data  in  W_DATA  pixel, raster order
- reload  in  1  request a new frame load (pulse)
- loaded  out  1  high while state is SERVE
- addr_valid  in  1  read request valid
- addr_ready  out  1  request accepted when valid & ready
- addr  in  W_ADDR  linear pixel address y*IMG_WIDTH+x
- dout_valid  out  1  returned pixel valid
- dout_ready  in  1  consumer ready
- dout_data  out  W_DATA  returned pixel
- err  out  1  sticky out-of-range flag (only with macro; tied 0 otherwise)

## Operation
- States: LOAD, SERVE, DRAIN.
- LOAD: wr_ready=1, addr_ready=0. Each wr handshake writes RAM[wr_cnt] and increments wr_cnt. The handshake with wr_cnt==IMG_WIDTH*IMG_HEIGHT-1 clears wr_cnt to 0 and moves to SERVE. reload is ignored.
- SERVE: wr_ready=0. addr_ready = (pend < DEPTH). pend counts accepted-but-not-yet-popped requests and is W=$clog2(DEPTH+1) bits. pend +1 on accept, −1 on dout handshake; both in the same cycle leave it unchanged. reload=1 moves to DRAIN.
- DRAIN: addr_ready=0. In-flight data continues to return normally. When pend==0, moves to LOAD.
- Read pipeline: cycle N accept registers addr into RAM; RAM output is valid in N+1 and is pushed into the FIFO; the FIFO head is visible as dout in N+2. The credit bound guarantees the FIFO never overflows.
- Output order equals request order. No reordering and no drops.
- rst mid-operation: state→LOAD, wr_cnt=0, pend=0, FIFO and pipeline emptied, err=0. RAM contents are not cleared.

## Timing
- Reset values: wr_ready=1, loaded=0, addr_ready=0, dout_valid=0, dout_data=0, err=0.
- Latency: accept at cycle N → dout_valid at N+2 at the earliest.
- Throughput: 1 pixel/cycle with dout_ready held high and DEPTH ≥ 3.
- addr_ready has no combinational dependence on dout_ready or addr_valid.
- dout_valid/dout_data stay stable while dout_valid & !dout_ready.
- Last load pixel at cycle N → loaded=1 and addr_ready=1 at N+1.
- reload at cycle N in SERVE → addr_ready=0 at N+1. If pend==0 at N+1, LOAD is entered at N+2.
- Simultaneous reload and addr accept in the same cycle: the request is accepted and served before LOAD is entered.

## Configuration
- IMG_MEM_OOB_CHECK_EN defined:
  - Any accepted addr ≥ IMG_WIDTH*IMG_HEIGHT returns data 0, still in order.
  - err is set from the next cycle and held until rst.
- Undefined: no range check. Out-of-range read data is unspecified, and err is tied 0.

## Structure
- Package img_mem_pkg holds:
  - the state enum (LOAD, SERVE, DRAIN);
  - a function for W_ADDR from width/height;
  - the frame pixel-count constant.
- One sub-module: sync_fifo (DEPTH, W_DATA; push/pop, show-ahead head, count output).
- The RAM is inferred inline as a single-port-read / single-port-write block RAM.

## Test plan
- Load 2050 pixels with pixel i = i mod 256, then request addr 0, 1, 2049 back-to-back with dout_ready=1 → outputs 0, 1, 1 (2049 mod 256) at cycles N+2, N+3, N+4.
- Hold dout_ready=0 while streaming requests → exactly DEPTH=4 accepts, then addr_ready=0. Release → 4 pixels out in order, and addr_ready returns 1 the cycle after the first pop.
- Issue reload with pend=3 → 3 pixels still delivered, loaded falls, and wr_ready=1 only after pend reaches 0.
- Assert rst mid-SERVE with pend=2 → next cycle dout_valid=0 and state LOAD. Reload a new frame; old data must not appear.
- With IMG_MEM_OOB_CHECK_EN, request addr 2050 → dout_data=0 and err=1, sticky. Without the macro, err stays 0.
- Random addr_valid/dout_ready (50%) over 10k requests → scoreboard matches RAM model exactly and in order.
